// File: rtl/keypad_multitap_p.sv
`default_nettype none
// keypad_multitap_p: scanned matrix keypad with debounce and multi-tap letter entry.
// Rev 1.0 - initial release.
module keypad_multitap_p #(
   parameter int ROWS            = 4,
   parameter int COLS            = 4,
   parameter int TAPS            = 3,
   parameter int SCAN_DWELL      = 4,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TAP_TIMEOUT     = 50
) (
   input  logic            clk,
   input  logic            nRst,
   input  logic [ROWS-1:0] row_in,
   output logic [COLS-1:0] col_out,
   output logic [7:0]      letter,
   output logic            letter_valid,
   input  logic            letter_ready,
   output logic [7:0]      preview,
   output logic            clear_pulse,
   output logic            error
);
   localparam int NKEYS = ROWS * COLS;
   localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int KW    = (NKEYS > 1) ? $clog2(NKEYS) : 1;
   localparam int TW    = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam int DW    = (SCAN_DWELL > 1) ? $clog2(SCAN_DWELL) : 1;
   localparam int BW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int OW    = $clog2(TAP_TIMEOUT + 1);

   localparam logic [1:0] SCAN       = 2'd0;
   localparam logic [1:0] DB_PRESS   = 2'd1;
   localparam logic [1:0] HELD       = 2'd2;
   localparam logic [1:0] DB_RELEASE = 2'd3;

   logic [ROWS-1:0] sync1, sync2, pat;
   logic [1:0]      state;
   logic [CW-1:0]   col_idx;
   logic [DW-1:0]   dwell;
   logic [BW-1:0]   db_cnt;
   logic            pend, pend_n;
   logic [KW-1:0]   pkey, pkey_n, ev_key;
   logic [TW-1:0]   ptap, ptap_n;
   logic [OW-1:0]   tmo;
   logic [7:0]      cur_code;
   logic            key_event, multi, commit, drop, clr, multi_err;

   function automatic logic slot_ok(input int k, input int t);
      return (65 + k * TAPS + t) <= 90;
   endfunction

   function automatic logic [7:0] code_of(input int k, input int t);
      int v;
      v = 65 + k * TAPS + t;
      return v[7:0];
   endfunction

   assign col_out   = COLS'(1) << col_idx;
   assign key_event = (state == DB_PRESS) && (sync2 == pat) && (db_cnt == BW'(DEBOUNCE_CYCLES - 1));
   assign multi     = (pat & (pat - ROWS'(1))) != '0;
   assign cur_code  = code_of(int'(pkey), int'(ptap));
   assign preview   = pend ? cur_code : 8'h00;
   assign drop      = commit && letter_valid && !letter_ready;

   always_comb begin
      ev_key = '0;
      for (int r = 0; r < ROWS; r++)
         if (pat[r]) ev_key = KW'(r * COLS + int'(col_idx));
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         sync1   <= '0;
         sync2   <= '0;
         state   <= SCAN;
         col_idx <= '0;
         dwell   <= '0;
         db_cnt  <= '0;
         pat     <= '0;
      end else begin
         sync1 <= row_in;
         sync2 <= sync1;
         case (state)
            SCAN: begin
               // Rows are sampled only on the last dwell cycle so the synchroniser has settled on this column.
               if (dwell == DW'(SCAN_DWELL - 1)) begin
                  dwell <= '0;
                  if (sync2 != '0) begin
                     state  <= DB_PRESS;
                     pat    <= sync2;
                     db_cnt <= '0;
                  end else begin
                     col_idx <= (col_idx == CW'(COLS - 1)) ? '0 : col_idx + CW'(1);
                  end
               end else begin
                  dwell <= dwell + DW'(1);
               end
            end
            DB_PRESS: begin
               if (sync2 != pat)                                 state  <= SCAN;
               else if (db_cnt == BW'(DEBOUNCE_CYCLES - 1))      state  <= HELD;
               else                                              db_cnt <= db_cnt + BW'(1);
            end
            HELD: begin
               if (sync2 == '0) begin
                  state  <= DB_RELEASE;
                  db_cnt <= '0;
               end
            end
            DB_RELEASE: begin
               if (sync2 != '0) begin
                  state <= HELD;
               end else if (db_cnt == BW'(DEBOUNCE_CYCLES - 1)) begin
                  state <= SCAN;
                  dwell <= '0;
               end else begin
                  db_cnt <= db_cnt + BW'(1);
               end
            end
            default: state <= SCAN;
         endcase
      end
   end

   always_comb begin
      pend_n    = pend;
      pkey_n    = pkey;
      ptap_n    = ptap;
      commit    = 1'b0;
      clr       = 1'b0;
      multi_err = 1'b0;
      if (key_event) begin
         if (multi) begin
            multi_err = 1'b1;
         end else if (ev_key == KW'(NKEYS - 1)) begin
            if (pend) begin
               commit = 1'b1;
               pend_n = 1'b0;
            end
         end else if (ev_key == KW'(NKEYS - 2)) begin
            pend_n = 1'b0;
            clr    = 1'b1;
         end else if (slot_ok(int'(ev_key), 0)) begin
            if (pend && (pkey == ev_key)) begin
               if ((int'(ptap) + 1 >= TAPS) || !slot_ok(int'(pkey), int'(ptap) + 1))
                  ptap_n = '0;
               else
                  ptap_n = ptap + TW'(1);
            end else begin
               commit = pend;
               pend_n = 1'b1;
               pkey_n = ev_key;
               ptap_n = '0;
            end
         end
      end else if (pend && (tmo == OW'(TAP_TIMEOUT))) begin
         commit = 1'b1;
         pend_n = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         pend         <= 1'b0;
         pkey         <= '0;
         ptap         <= '0;
         tmo          <= '0;
         letter       <= '0;
         letter_valid <= 1'b0;
         clear_pulse  <= 1'b0;
         error        <= 1'b0;
      end else begin
         pend <= pend_n;
         pkey <= pkey_n;
         ptap <= ptap_n;
         // The idle timer only runs while scanning with a letter pending.
         if (key_event || commit || !pend || (state == HELD) || (state == DB_RELEASE))
            tmo <= '0;
         else
            tmo <= tmo + OW'(1);
         clear_pulse <= clr;
         error       <= multi_err || drop;
         if (commit && !drop) begin
            letter       <= cur_code;
            letter_valid <= 1'b1;
         end else if (letter_valid && letter_ready) begin
            letter_valid <= 1'b0;
         end
      end
   end
endmodule
`default_nettype wire

// File: doc/keypad_multitap_p.md
KEYPAD_MULTITAP_P -- requirements
Module: keypad_multitap_p

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of keypad row inputs.
REQ-002 SHALL have parameter COLS, default 4, number of column drive outputs.
REQ-003 SHALL have parameter TAPS, default 3, letters per letter key.
REQ-004 SHALL have parameter SCAN_DWELL, default 4, cycles each column is driven (minimum 3).
REQ-005 SHALL have parameter DEBOUNCE_CYCLES, default 4, stable samples required for press/release.
REQ-006 SHALL have parameter TAP_TIMEOUT, default 50, idle cycles after release before auto-commit.
REQ-007 SHALL have port clk  input  1  single clock, rising edge.
REQ-008 SHALL have port nRst  input  1  asynchronous active-low reset.
REQ-009 SHALL have port row_in  input  ROWS  raw active-high row lines, asynchronous.
REQ-010 SHALL have port col_out  output  COLS  one-hot active-high column drive.
REQ-011 SHALL have port letter  output  8  committed ASCII letter.
REQ-012 SHALL have port letter_valid  output  1  letter held valid until accepted.
REQ-013 SHALL have port letter_ready  input  1  consumer accepts letter when high with letter_valid.
REQ-014 SHALL have port preview  output  8  ASCII of pending (uncommitted) letter, 8'h00 when none.
REQ-015 SHALL have port clear_pulse  output  1  one-cycle pulse on clear key.
REQ-016 SHALL have port error  output  1  one-cycle pulse on multi-row press or dropped commit.

Function
REQ-017 SHALL pass row_in through a 2-flop synchroniser before any use.
REQ-018 SHALL number keys k = r*COLS + c; key N-1 (N=ROWS*COLS) is submit, key N-2 is clear, keys 0..N-3 are letter keys.
REQ-019 SHALL map letter key k, tap t to 'A' + k*TAPS + t; codes above 'Z' are invalid slots; a key whose tap-0 code is invalid is a no-op.
REQ-020 SHALL implement scan FSM states SCAN, DB_PRESS, HELD, DB_RELEASE.
REQ-021 SCAN: col_out rotates one-hot col0->col(COLS-1)->col0 every SCAN_DWELL cycles; synchronised rows sampled on last dwell cycle; nonzero -> DB_PRESS with column frozen.
REQ-022 DB_PRESS: same row pattern for DEBOUNCE_CYCLES consecutive cycles -> HELD and one key event; any change -> SCAN without event.
REQ-023 A key event with more than one row bit set SHALL pulse error and be discarded; FSM still goes to HELD.
REQ-024 HELD: rows all-zero -> DB_RELEASE; DB_RELEASE: zero for DEBOUNCE_CYCLES -> SCAN, nonzero -> HELD.
REQ-025 Letter key event with no pending letter: pending key=k, tap=0, preview updates the cycle after the event.
REQ-026 Same letter key again while pending: tap increments; invalid slot or tap=TAPS wraps to 0.
REQ-027 Different letter key while pending: commit old letter, start new key at tap 0 in the same cycle.
REQ-028 Submit event with pending letter: commit; with none: no action.
REQ-029 Clear event: drop pending, preview=0, clear_pulse for one cycle; letter_valid unaffected.
REQ-030 Timeout counter SHALL start on entry to SCAN with a pending letter, reset on any key event, and commit when it reaches TAP_TIMEOUT.
REQ-031 Commit: letter/letter_valid registered next cycle, preview=0; letter holds stable while letter_valid and not letter_ready.
REQ-032 letter_valid drops the cycle after letter_valid&&letter_ready; commit in that same cycle loads new letter with valid kept high.
REQ-033 Commit while letter_valid high and letter_ready low SHALL drop the new letter and pulse error.

Reset
REQ-034 nRst low SHALL immediately force SCAN, col_out=1 (col0), letter=0, letter_valid=0, preview=0, clear_pulse=0, error=0, tap/timeout counters 0, synchroniser flops 0.
REQ-035 Reset mid-debounce or mid-tap SHALL discard pending letter without commit.

Verification
REQ-036 Key0 (row0,col0) once, release, wait 50 idle cycles -> letter='A', letter_valid high until letter_ready.
REQ-037 Key1 tapped twice, then submit key 15 -> letter='E' before timeout; preview 'D' then 'E' then 0.
REQ-038 Key8 tapped three times -> preview 'Y','Z','Y' (invalid slot wraps); submit -> 'Y'.
REQ-039 Key0 then key1 without waiting -> 'A' committed on key1 event, preview 'D'; clear key14 -> clear_pulse, preview 0, no 'D'.
REQ-040 Row pattern 4'b0011 held stable -> error pulse, no preview; 2-cycle glitch on row0 -> no event.
REQ-041 letter_ready low, commit 'A' then 'D' -> 'A' held, error pulse on 'D'; nRst low mid-tap -> all outputs to reset values.
